keystream_encryptor: RTL and testbench
======================================

KEYSTREAM_ENCRYPTOR -- requirements
Module: keystream_encryptor

Interface
REQ-001 SHALL have parameter TAPS, default 16'hB400, Galois LFSR feedback mask.
REQ-002 SHALL have parameter SAFE_SEED, default 16'hACE1, substituted for an all-zero seed.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port seed_in  input  16  LFSR seed value.
REQ-006 SHALL have port seed_load  input  1  one-cycle pulse; load seed_in.
REQ-007 SHALL have port data_in  input  8  plaintext byte from interface FSM.
REQ-008 SHALL have port data_in_pulse  input  1  one-cycle strobe; data_in valid.
REQ-009 SHALL have port busy  output  1  high while a byte is in flight.
REQ-010 SHALL have port drop_flag  output  1  sticky; a strobe was discarded.
REQ-011 SHALL have port data_out  output  8  ciphertext byte to output holder.
REQ-012 SHALL have port data_out_pulse  output  1  one-cycle strobe; data_out valid.

Function
REQ-013 SHALL implement states IDLE, SHIFT, EMIT; reset state IDLE.
REQ-014 IDLE: on data_in_pulse, SHALL latch data_in, clear the 3-bit bit counter, clear the keystream register and go to SHIFT.
REQ-015 SHIFT: each cycle SHALL set ks <= {ks[6:0], lfsr[0]} and lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0), then increment the counter.
REQ-016 SHIFT SHALL last exactly 8 cycles; counter wrap 7->0 SHALL move to EMIT.
REQ-017 EMIT: SHALL register data_out = latched byte XOR ks, pulse data_out_pulse for one cycle and return to IDLE.
REQ-018 Latency SHALL be fixed: strobe sampled at edge N gives data_out_pulse high in the cycle after edge N+9.
REQ-019 busy SHALL be high from edge N through edge N+9, and low in IDLE.
REQ-020 A data_in_pulse while not IDLE SHALL be discarded and SHALL set drop_flag.
REQ-021 seed_load SHALL load lfsr <= (seed_in == 0) ? SAFE_SEED : seed_in in any state.
REQ-022 seed_load in SHIFT or EMIT SHALL abort the byte: no data_out_pulse, data_out unchanged, next state IDLE.
REQ-023 seed_load together with data_in_pulse in IDLE: seed SHALL win, the byte SHALL be dropped and drop_flag SHALL be set.
REQ-024 data_out SHALL hold its last value between pulses.
REQ-025 The LFSR SHALL advance only in SHIFT, or by seed_load.

Reset
REQ-026 rst SHALL force: state IDLE, lfsr = SAFE_SEED, counter 0, ks 0, data_out 8'h00, data_out_pulse 0, busy 0, drop_flag 0.
REQ-027 rst SHALL take priority over seed_load and data_in_pulse in the same cycle, including mid-operation.
REQ-028 drop_flag SHALL be cleared only by rst or by seed_load.

Configuration
REQ-029 Macro KEYSTREAM_CHAIN_EN, when defined, SHALL have EMIT also apply lfsr[7:0] <= lfsr[7:0] ^ data_out_next (ciphertext feedback).
REQ-030 Without KEYSTREAM_CHAIN_EN, the LFSR SHALL be untouched in EMIT.

Structure
REQ-031 The shared stream_cipher package SHALL hold the state enum type (enc_state_t) and the default TAPS and SAFE_SEED constants.
REQ-032 The LFSR step SHALL be one sub-module, galois_lfsr16 (load, enable, seed, state out); the FSM and XOR stay in keystream_encryptor.

Verification
REQ-033 Reset, then seed_load 16'hACE1, then data_in 8'h00 -> data_out 8'h87 with data_out_pulse 10 cycles after the strobe edge, and lfsr = 16'hC2C4 after.
REQ-034 Same seed, data_in 8'h41 -> data_out 8'hC6; busy high for exactly 10 cycles.
REQ-035 seed_load 16'h0000, data_in 8'h00 -> data_out 8'h87 (SAFE_SEED substitution).
REQ-036 Second data_in_pulse 3 cycles after the first -> one data_out_pulse only, drop_flag = 1; a later seed_load clears drop_flag.
REQ-037 seed_load at SHIFT cycle 4 -> no data_out_pulse, data_out unchanged, busy low next cycle; rst at SHIFT cycle 4 -> all outputs at reset values.
REQ-038 With KEYSTREAM_CHAIN_EN, seed 16'hACE1, bytes 8'h00 then 8'h00 -> first 8'h87; the second byte differs from the non-chained run.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the keystream cipher: encryptor FSM state type and
// the default LFSR feedback mask and all-zero-seed substitute.
package stream_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2
    } enc_state_t;

    localparam logic [15:0] DEFAULT_TAPS      = 16'hB400;
    localparam logic [15:0] DEFAULT_SAFE_SEED = 16'hACE1;

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit right-shifting Galois LFSR. A load takes priority over a step and
// replaces the whole state with load_val.
module galois_lfsr16 #(
    parameter logic [15:0] TAPS      = 16'hB400,
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] load_val,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (enable) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/keystream_encryptor.sv
// Byte-serial keystream encryptor: gathers 8 LFSR bits per byte and XORs them
// into the plaintext. Define KEYSTREAM_CHAIN_EN to fold each ciphertext byte back into the LFSR.
module keystream_encryptor
    import stream_cipher_pkg::*;
#(
    parameter logic [15:0] TAPS      = DEFAULT_TAPS,
    parameter logic [15:0] SAFE_SEED = DEFAULT_SAFE_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed_in,
    input  logic        seed_load,
    input  logic [7:0]  data_in,
    input  logic        data_in_pulse,
    output logic        busy,
    output logic        drop_flag,
    output logic [7:0]  data_out,
    output logic        data_out_pulse
);

    // Strobe semantics: data_in is taken on the single cycle data_in_pulse is
    // high; there is no back-pressure, so a strobe outside IDLE (or alongside
    // seed_load) is lost and recorded in drop_flag.

    enc_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  ks_q, ks_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        pulse_q, pulse_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;

    logic [15:0] lfsr_state;
    logic        lfsr_load;
    logic        lfsr_en;
    logic [15:0] lfsr_load_val;
    logic [7:0]  data_out_next;

    assign data_out_next = byte_q ^ ks_q;

    galois_lfsr16 #(
        .TAPS      (TAPS),
        .RESET_VAL (SAFE_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .enable   (lfsr_en),
        .load_val (lfsr_load_val),
        .lfsr_out (lfsr_state)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ks_d          = ks_q;
        byte_d        = byte_q;
        data_out_d    = data_out_q;
        pulse_d       = 1'b0;
        drop_d        = drop_q;
        lfsr_load     = 1'b0;
        lfsr_en       = 1'b0;
        lfsr_load_val = lfsr_state;

        case (state_q)
            IDLE: begin
                if (data_in_pulse && !seed_load) begin
                    byte_d  = data_in;
                    cnt_d   = 3'd0;
                    ks_d    = 8'h00;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ks_d    = {ks_q[6:0], lfsr_state[0]};
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                data_out_d = data_out_next;
                pulse_d    = 1'b1;
                state_d    = IDLE;
`ifdef KEYSTREAM_CHAIN_EN
                lfsr_load     = 1'b1;
                lfsr_load_val = {lfsr_state[15:8], lfsr_state[7:0] ^ data_out_next};
`else
                lfsr_load     = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reseed overrides everything above and aborts any byte in flight.
        if (seed_load) begin
            state_d       = IDLE;
            cnt_d         = 3'd0;
            data_out_d    = data_out_q;
            pulse_d       = 1'b0;
            lfsr_en       = 1'b0;
            lfsr_load     = 1'b1;
            lfsr_load_val = (seed_in == 16'h0000) ? SAFE_SEED : seed_in;
            drop_d        = 1'b0;
        end

        if (data_in_pulse && (state_q != IDLE || seed_load)) begin
            drop_d = 1'b1;
        end
    end

    // busy also covers the output-pulse cycle, so it spans the full 10 cycles.
    assign busy_d = (state_d != IDLE) || pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ks_q       <= 8'h00;
            byte_q     <= 8'h00;
            data_out_q <= 8'h00;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ks_q       <= ks_d;
            byte_q     <= byte_d;
            data_out_q <= data_out_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign busy           = busy_q;
    assign drop_flag      = drop_q;
    assign data_out       = data_out_q;
    assign data_out_pulse = pulse_q;

endmodule

// File: tb/tb_keystream_encryptor.sv
// Self-checking bench for keystream_encryptor: a behavioural keystream model
// fills an expected queue, and a monitor captures every data_out_pulse.
module tb_keystream_encryptor;

    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] SAFE_SEED = 16'hACE1;

`ifdef KEYSTREAM_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seed_in;
    logic        seed_load;
    logic [7:0]  data_in;
    logic        data_in_pulse;
    logic        busy;
    logic        drop_flag;
    logic [7:0]  data_out;
    logic        data_out_pulse;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] model_lfsr;
    logic [7:0]  last_out;

    keystream_encryptor dut (
        .clk            (clk),
        .rst            (rst),
        .seed_in        (seed_in),
        .seed_load      (seed_load),
        .data_in        (data_in),
        .data_in_pulse  (data_in_pulse),
        .busy           (busy),
        .drop_flag      (drop_flag),
        .data_out       (data_out),
        .data_out_pulse (data_out_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (data_out_pulse) begin
            got_q.push_back(data_out);
        end
    end

    // ---------------- model ----------------
    task automatic model_byte(input logic [15:0] lf_in, input logic [7:0] d, input bit chain,
                              output logic [7:0] c, output logic [15:0] lf_out);
        logic [15:0] lf;
        logic [7:0]  ks;
        lf = lf_in;
        ks = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ks = {ks[6:0], lf[0]};
            lf = lf[0] ? ((lf >> 1) ^ TAPS) : (lf >> 1);
        end
        c = d ^ ks;
        if (chain) begin
            lf[7:0] = lf[7:0] ^ c;
        end
        lf_out = lf;
    endtask

    // ---------------- drivers ----------------
    task automatic do_seed(input logic [15:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_lfsr = (s == 16'h0000) ? SAFE_SEED : s;
    endtask

    // Pushes the model result, sends one byte and waits (bounded) for the pulse.
    task automatic send_byte(input logic [7:0] d, output int lat, output int busy_cnt);
        logic [7:0]  c;
        logic [15:0] nl;
        model_byte(model_lfsr, d, CHAIN, c, nl);
        model_lfsr = nl;
        exp_q.push_back(c);
        data_in       = d;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!data_out_pulse && lat < 30) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        tick();
        if (busy) busy_cnt++;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        tick();
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        n_checks++; if (data_out_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", data_out_pulse); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", drop_flag); end
        n_checks++; if (dut.lfsr_state !== SAFE_SEED) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_state, SAFE_SEED); end
        model_lfsr = SAFE_SEED;
        last_out = 8'h00;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [7:0] e, g;
        do_seed(16'hACE1);
        send_byte(8'h00, lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); got_q.delete(); end
        else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", g, e); end last_out = g; end
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9 edges after strobe edge", lat); end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL basic_lfsr got=%h exp=%h", dut.lfsr_state, model_lfsr); end
    endtask

    task automatic test_byte_41();
        int lat, bc;
        logic [7:0] e, g;
        do_seed(16'hACE1);
        send_byte(8'h41, lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL b41_count got=%0d exp=1", got_q.size()); got_q.delete(); end
        else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b41_data got=%h exp=%h", g, e); end last_out = g; end
        n_checks++; if (bc != 10) begin n_fail++; $display("FAIL b41_busy_cycles got=%0d exp=10", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b41_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_safe_seed();
        int lat, bc;
        logic [7:0] e, g;
        do_seed(16'h0000);
        n_checks++; if (dut.lfsr_state !== SAFE_SEED) begin n_fail++; $display("FAIL safe_seed_lfsr got=%h exp=%h", dut.lfsr_state, SAFE_SEED); end
        send_byte(8'h00, lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL safe_count got=%0d exp=1", got_q.size()); got_q.delete(); end
        else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL safe_data got=%h exp=%h", g, e); end last_out = g; end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [7:0] e, g;
        for (int r = 0; r < 4; r++) begin
            do_seed(16'($urandom_range(0, 65535)));
            for (int b = 0; b < 3; b++) begin
                send_byte(8'($urandom_range(0, 255)), lat, bc);
                e = exp_q.pop_front();
                n_checks++;
                if (got_q.size() != 1) begin n_fail++; $display("FAIL b2b_count r=%0d b=%0d got=%0d exp=1", r, b, got_q.size()); got_q.delete(); end
                else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b2b_data r=%0d b=%0d got=%h exp=%h", r, b, g, e); end last_out = g; end
            end
            n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL b2b_lfsr r=%0d got=%h exp=%h", r, dut.lfsr_state, model_lfsr); end
        end
    endtask

    task automatic test_abort();
        do_seed(16'h1357);
        data_in       = 8'h5A;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
        wait_cycles(3);
        seed_in   = 16'h2468;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_lfsr = 16'h2468;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL abort_lfsr got=%h exp=%h", dut.lfsr_state, model_lfsr); end
        wait_cycles(15);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_pulse got=%0d pulses exp=0", got_q.size()); got_q.delete(); end
        n_checks++; if (data_out !== last_out) begin n_fail++; $display("FAIL abort_data_out got=%h exp=%h", data_out, last_out); end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL abort_lfsr_idle got=%h exp=%h", dut.lfsr_state, model_lfsr); end
    endtask

    task automatic test_drop();
        logic [7:0]  c;
        logic [15:0] nl;
        logic [7:0]  g;
        do_seed(16'hACE1);
        model_byte(model_lfsr, 8'h3C, CHAIN, c, nl);
        model_lfsr = nl;
        exp_q.push_back(c);
        data_in       = 8'h3C;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
        wait_cycles(2);
        data_in       = 8'hFF;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
        wait_cycles(15);
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL drop_count got=%0d exp=1", got_q.size()); got_q.delete(); void'(exp_q.pop_front()); end
        else begin g = got_q.pop_front(); c = exp_q.pop_front(); if (g !== c) begin n_fail++; $display("FAIL drop_data got=%h exp=%h", g, c); end last_out = g; end
        n_checks++; if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL drop_flag_set got=%b exp=1", drop_flag); end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL drop_lfsr got=%h exp=%h", dut.lfsr_state, model_lfsr); end
        do_seed(16'hBEEF);
        n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL drop_flag_clear got=%b exp=0", drop_flag); end
        // Seed and strobe together in IDLE: the seed is taken, the byte is lost.
        seed_in       = 16'h1234;
        seed_load     = 1'b1;
        data_in       = 8'h77;
        data_in_pulse = 1'b1;
        tick();
        seed_load     = 1'b0;
        data_in_pulse = 1'b0;
        model_lfsr    = 16'h1234;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seed_wins_busy got=%b exp=0", busy); end
        wait_cycles(12);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL seed_wins_pulse got=%0d exp=0", got_q.size()); got_q.delete(); end
        n_checks++; if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL seed_wins_drop got=%b exp=1", drop_flag); end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL seed_wins_lfsr got=%h exp=%h", dut.lfsr_state, model_lfsr); end
    endtask

    task automatic test_rst_mid();
        data_in       = 8'h99;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
        wait_cycles(3);
        rst           = 1'b1;
        seed_in       = 16'h4242;
        seed_load     = 1'b1;
        data_in_pulse = 1'b1;
        tick();
        rst           = 1'b0;
        seed_load     = 1'b0;
        data_in_pulse = 1'b0;
        model_lfsr    = SAFE_SEED;
        last_out      = 8'h00;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data_out got=%h exp=00", data_out); end
        n_checks++; if (data_out_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse got=%b exp=0", data_out_pulse); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop got=%b exp=0", drop_flag); end
        n_checks++; if (dut.lfsr_state !== SAFE_SEED) begin n_fail++; $display("FAIL rst_mid_lfsr got=%h exp=%h", dut.lfsr_state, SAFE_SEED); end
        wait_cycles(12);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_chain();
        int lat, bc;
        logic [7:0]  e, g, plain2, dummy;
        logic [15:0] lf_plain;
        model_byte(SAFE_SEED, 8'h00, 1'b0, dummy, lf_plain);
        model_byte(lf_plain, 8'h00, 1'b0, plain2, lf_plain);
        do_seed(16'hACE1);
        for (int b = 0; b < 2; b++) begin
            send_byte(8'h00, lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() != 1) begin n_fail++; $display("FAIL chain_count b=%0d got=%0d exp=1", b, got_q.size()); got_q.delete(); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL chain_data b=%0d got=%h exp=%h", b, g, e); end
                last_out = g;
`ifdef KEYSTREAM_CHAIN_EN
                if (b == 1) begin
                    n_checks++;
                    if (g === plain2) begin n_fail++; $display("FAIL chain_differs got=%h exp=not %h", g, plain2); end
                end
`endif
            end
        end
        n_checks++; if (dut.lfsr_state !== model_lfsr) begin n_fail++; $display("FAIL chain_lfsr got=%h exp=%h", dut.lfsr_state, model_lfsr); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst           = 1'b1;
        seed_in       = 16'h0000;
        seed_load     = 1'b0;
        data_in       = 8'h00;
        data_in_pulse = 1'b0;
        model_lfsr    = SAFE_SEED;
        last_out      = 8'h00;
        test_reset();
        test_basic();
        test_byte_41();
        test_safe_seed();
        test_back_to_back();
        test_abort();
        test_drop();
        test_rst_mid();
        test_chain();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
